barcode_2of5_decoder: RTL and testbench

- Parametrised successor of the fixed-format bar code reader.
- Decodes a serial sampled bar/space stream, coded as 2-of-5 (bars carry data, spaces are separators), into a frame of DIGITS decimal digits.
- Checks start and stop patterns, flags pattern, timeout and overrun errors, and signals frame completion.
- Sits between the optical sampler and the downstream lookup/display logic.

---
 rtl/barcode_2of5_decoder_if.sv | 36 +++
 rtl/barcode_2of5_decoder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_barcode_2of5_decoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/barcode_2of5_decoder_if.sv
// Scanner-side sample input and decoded digit/frame results of the 2-of-5 decoder.
// The decoder takes the master modport; the downstream consumer takes slave.
interface barcode_2of5_decoder_if #(
    parameter int DIGITS = 4
);
    logic                bar_in;
    logic                digit_valid;
    logic [3:0]          digit_data;
    logic [3:0]          digit_idx;
    logic [4*DIGITS-1:0] frame_digits;
    logic                frame_done;
    logic                frame_error;
    logic [1:0]          err_code;

    modport master (
        input  bar_in,
        output digit_valid,
        output digit_data,
        output digit_idx,
        output frame_digits,
        output frame_done,
        output frame_error,
        output err_code
    );

    modport slave (
        output bar_in,
        input  digit_valid,
        input  digit_data,
        input  digit_idx,
        input  frame_digits,
        input  frame_done,
        input  frame_error,
        input  err_code
    );
endinterface

// File: rtl/barcode_2of5_decoder.sv
// Serial 2-of-5 bar code decoder: start WWN, DIGITS digits, stop WNW.
// Define BARCODE_CHECKSUM_EN to treat the last digit as a 3,1,3,1 mod-10 check digit.
module barcode_2of5_decoder #(
    parameter int DIGITS   = 4,
    parameter int CNT_W    = 8,
    parameter int WIDE_MIN = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    barcode_2of5_decoder_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WIDE_LEN = CNT_W'(WIDE_MIN);
    localparam logic [3:0]       LAST_IDX = 4'(DIGITS - 1);

    state_t              state, state_n;
    logic                bar_q;
    logic [CNT_W-1:0]    bar_cnt, spc_cnt;
    logic [2:0]          bcnt, bcnt_n;
    logic [2:0]          pat, pat_n;
    logic [2:0]          nwide, nwide_n;
    logic [4:0]          dsum, dsum_n;
    logic [3:0]          dcnt, dcnt_n;
    logic                dv, dv_n;
    logic [3:0]          ddata, ddata_n;
    logic [3:0]          didx, didx_n;
    logic [4*DIGITS-1:0] fdig, fdig_n;
    logic                fdone, fdone_n;
    logic                ferr, ferr_n;
    logic [1:0]          ecode, ecode_n;
`ifdef BARCODE_CHECKSUM_EN
    logic [3:0]          csum, csum_n;
`endif

    logic       eob, wide, ovr, tmo;
    logic [2:0] pat_full, nwide_full;
    logic [4:0] dsum_full;
    logic [3:0] digit;
    logic       err;
    logic [1:0] code;

    function automatic logic [4:0] wt(input logic [2:0] i);
        unique case (i)
            3'd0:    wt = 5'd1;
            3'd1:    wt = 5'd2;
            3'd2:    wt = 5'd4;
            3'd3:    wt = 5'd7;
            default: wt = 5'd0;
        endcase
    endfunction

`ifdef BARCODE_CHECKSUM_EN
    function automatic logic [3:0] mod10(input logic [5:0] s);
        if (s >= 6'd30)      mod10 = 4'(s - 6'd30);
        else if (s >= 6'd20) mod10 = 4'(s - 6'd20);
        else if (s >= 6'd10) mod10 = 4'(s - 6'd10);
        else                 mod10 = s[3:0];
    endfunction
`endif

    assign eob        = bar_q & ~bus.bar_in;
    assign wide       = bar_cnt >= WIDE_LEN;
    assign ovr        = bar_cnt == CNT_MAX;
    assign tmo        = ~bus.bar_in & (spc_cnt == TMO_LAST);
    assign pat_full   = {pat[1:0], wide};
    assign nwide_full = nwide + 3'(wide);
    assign dsum_full  = dsum + (wide ? wt(bcnt) : 5'd0);
    // A 4+7 pair encodes zero.
    assign digit      = (dsum_full == 5'd11) ? 4'd0 : dsum_full[3:0];

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        pat_n   = pat;
        nwide_n = nwide;
        dsum_n  = dsum;
        dcnt_n  = dcnt;
        dv_n    = 1'b0;
        ddata_n = ddata;
        didx_n  = didx;
        fdig_n  = fdig;
        fdone_n = 1'b0;
        ferr_n  = 1'b0;
        ecode_n = ecode;
        err     = 1'b0;
        code    = 2'd0;
`ifdef BARCODE_CHECKSUM_EN
        csum_n  = csum;
`endif
        unique case (state)
            IDLE: begin
                if (bus.bar_in) begin
                    state_n = START;
                    bcnt_n  = 3'd0;
                    pat_n   = 3'd0;
                    fdig_n  = '0;
                end
            end
            START: begin
                if (tmo) begin
                    err  = 1'b1;
                    code = 2'd2;
                end else if (eob) begin
                    if (ovr) begin
                        err  = 1'b1;
                        code = 2'd3;
                    end else if (bcnt == 3'd2) begin
                        if (pat_full == 3'b110) begin
                            state_n = DATA;
                            bcnt_n  = 3'd0;
                            nwide_n = 3'd0;
                            dsum_n  = 5'd0;
                            dcnt_n  = 4'd0;
`ifdef BARCODE_CHECKSUM_EN
                            csum_n  = 4'd0;
`endif
                        end else begin
                            err  = 1'b1;
                            code = 2'd1;
                        end
                    end else begin
                        bcnt_n = bcnt + 3'd1;
                        pat_n  = pat_full;
                    end
                end
            end
            DATA: begin
                if (tmo) begin
                    err  = 1'b1;
                    code = 2'd2;
                end else if (eob) begin
                    if (ovr) begin
                        err  = 1'b1;
                        code = 2'd3;
                    end else if (bcnt == 3'd4) begin
                        if (nwide_full == 3'd2) begin
                            dv_n    = 1'b1;
                            ddata_n = digit;
                            didx_n  = dcnt;
                            for (int i = 0; i < DIGITS; i++)
                                if (dcnt == 4'(i))
                                    fdig_n[4*i +: 4] = digit;
`ifdef BARCODE_CHECKSUM_EN
                            // Even positions weigh 3, odd positions weigh 1.
                            csum_n = mod10({2'b00, csum} + {2'b00, digit}
                                     + (dcnt[0] ? 6'd0 : {1'b0, digit, 1'b0}));
`endif
                            bcnt_n  = 3'd0;
                            nwide_n = 3'd0;
                            dsum_n  = 5'd0;
                            if (dcnt == LAST_IDX) begin
                                state_n = STOP;
                                pat_n   = 3'd0;
                            end else begin
                                dcnt_n = dcnt + 4'd1;
                            end
                        end else begin
                            err  = 1'b1;
                            code = 2'd1;
                        end
                    end else begin
                        bcnt_n  = bcnt + 3'd1;
                        nwide_n = nwide_full;
                        dsum_n  = dsum_full;
                    end
                end
            end
            STOP: begin
                if (tmo) begin
                    err  = 1'b1;
                    code = 2'd2;
                end else if (eob) begin
                    if (ovr) begin
                        err  = 1'b1;
                        code = 2'd3;
                    end else if (bcnt == 3'd2) begin
                        if (pat_full == 3'b101) begin
                            state_n = IDLE;
`ifdef BARCODE_CHECKSUM_EN
                            if (csum != 4'd0) begin
                                err  = 1'b1;
                                code = 2'd3;
                            end else begin
                                fdone_n = 1'b1;
                            end
`else
                            fdone_n = 1'b1;
`endif
                        end else begin
                            err  = 1'b1;
                            code = 2'd1;
                        end
                    end else begin
                        bcnt_n = bcnt + 3'd1;
                        pat_n  = pat_full;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (err) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
            ecode_n = code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bar_q   <= 1'b0;
            bar_cnt <= '0;
            spc_cnt <= '0;
            bcnt    <= 3'd0;
            pat     <= 3'd0;
            nwide   <= 3'd0;
            dsum    <= 5'd0;
            dcnt    <= 4'd0;
            dv      <= 1'b0;
            ddata   <= 4'd0;
            didx    <= 4'd0;
            fdig    <= '0;
            fdone   <= 1'b0;
            ferr    <= 1'b0;
            ecode   <= 2'd0;
`ifdef BARCODE_CHECKSUM_EN
            csum    <= 4'd0;
`endif
        end else begin
            state   <= state_n;
            bar_q   <= bus.bar_in;
            if (bus.bar_in) begin
                bar_cnt <= (bar_cnt == CNT_MAX) ? CNT_MAX : bar_cnt + 1'b1;
                spc_cnt <= '0;
            end else begin
                bar_cnt <= '0;
                spc_cnt <= (spc_cnt == CNT_MAX) ? CNT_MAX : spc_cnt + 1'b1;
            end
            bcnt    <= bcnt_n;
            pat     <= pat_n;
            nwide   <= nwide_n;
            dsum    <= dsum_n;
            dcnt    <= dcnt_n;
            dv      <= dv_n;
            ddata   <= ddata_n;
            didx    <= didx_n;
            fdig    <= fdig_n;
            fdone   <= fdone_n;
            ferr    <= ferr_n;
            ecode   <= ecode_n;
`ifdef BARCODE_CHECKSUM_EN
            csum    <= csum_n;
`endif
        end
    end

    assign bus.digit_valid  = dv;
    assign bus.digit_data   = ddata;
    assign bus.digit_idx    = didx;
    assign bus.frame_digits = fdig;
    assign bus.frame_done   = fdone;
    assign bus.frame_error  = ferr;
    assign bus.err_code     = ecode;
endmodule

// File: tb/tb_barcode_2of5_decoder.sv
// Scoreboard bench for barcode_2of5_decoder: directed frames, errors, reset.
// Honours BARCODE_CHECKSUM_EN when the design is built with it.
module tb_barcode_2of5_decoder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_zero = 1'b0;
    bit   chk_end  = 1'b0;

    typedef struct {
        logic [3:0] idx;
        logic [3:0] data;
    } dig_t;

    typedef struct {
        bit          done;
        logic [1:0]  code;
        logic [15:0] digits;
        int          due;
    } frm_t;

    dig_t dq[$];
    frm_t fq[$];

    barcode_2of5_decoder_if #(.DIGITS(4)) bif ();

    barcode_2of5_decoder #(
        .DIGITS(4), .CNT_W(8), .WIDE_MIN(4), .TIMEOUT(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic unexp(input string n);
        total++;
        bad++;
        $display("FAIL %s: got unexpected pulse want none", n);
    endtask

    always @(negedge clock) begin
        dig_t de;
        frm_t fe;
        if (chk_zero) begin
            cmp("rst_ctrl", 32'({bif.digit_valid, bif.digit_data, bif.digit_idx,
                bif.frame_done, bif.frame_error, bif.err_code}), 32'd0);
            cmp("rst_frame", 32'(bif.frame_digits), 32'd0);
        end
        if (!reset) begin
            if (bif.digit_valid) begin
                if (dq.size() == 0) unexp("digit_valid");
                else begin
                    de = dq.pop_front();
                    cmp("digit_idx", 32'(bif.digit_idx), 32'(de.idx));
                    cmp("digit_data", 32'(bif.digit_data), 32'(de.data));
                end
            end
            if (bif.frame_done || bif.frame_error) begin
                if (fq.size() == 0) unexp("frame_end");
                else begin
                    fe = fq.pop_front();
                    cmp("frame_done", 32'(bif.frame_done), 32'(fe.done));
                    cmp("frame_error", 32'(bif.frame_error), 32'(!fe.done));
                    cmp("frame_digits", 32'(bif.frame_digits), 32'(fe.digits));
                    if (!fe.done) cmp("err_code", 32'(bif.err_code), 32'(fe.code));
                    if (fe.due >= 0) cmp("frame_cycle", 32'(cyc), 32'(fe.due));
                end
            end
        end
        if (chk_end) begin
            cmp("digits_left", 32'(dq.size()), 32'd0);
            cmp("frames_left", 32'(fq.size()), 32'd0);
        end
    end

    // Bar widths in receive order, MSB first; weights 1,2,4,7,0.
    function automatic logic [4:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 5'b00110;
            4'd1: enc = 5'b10001;
            4'd2: enc = 5'b01001;
            4'd3: enc = 5'b11000;
            4'd4: enc = 5'b00101;
            4'd5: enc = 5'b10100;
            4'd6: enc = 5'b01100;
            4'd7: enc = 5'b00011;
            4'd8: enc = 5'b10010;
            default: enc = 5'b01010;
        endcase
    endfunction

    task automatic bar_hi(input int w);
        bif.bar_in = 1'b1;
        repeat (w) @(posedge clock);
        #1;
        bif.bar_in = 1'b0;
    endtask

    task automatic space(input int n);
        bif.bar_in = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sbar(input bit w);
        bar_hi(w ? 6 : 2);
        space(2);
    endtask

    task automatic send_digit(input logic [3:0] d);
        logic [4:0] m;
        m = enc(d);
        for (int i = 4; i >= 0; i--) sbar(m[i]);
    endtask

    task automatic send_start();
        sbar(1'b1);
        sbar(1'b1);
        sbar(1'b0);
    endtask

    task automatic push_dig(input int i, input logic [3:0] d);
        dig_t e;
        e.idx  = 4'(i);
        e.data = d;
        dq.push_back(e);
    endtask

    task automatic push_frm(input bit done, input logic [1:0] c,
                            input logic [15:0] dg, input int due);
        frm_t e;
        e.done   = done;
        e.code   = c;
        e.digits = dg;
        e.due    = due;
        fq.push_back(e);
    endtask

    task automatic run_frame(input logic [15:0] v);
        bit ok;
        int s;
        s  = 0;
        ok = 1'b1;
`ifdef BARCODE_CHECKSUM_EN
        s  = 3 * int'(v[3:0]) + int'(v[7:4]) + 3 * int'(v[11:8]) + int'(v[15:12]);
        ok = (s % 10) == 0;
`endif
        send_start();
        for (int i = 0; i < 4; i++) begin
            push_dig(i, v[4*i +: 4]);
            send_digit(v[4*i +: 4]);
        end
        sbar(1'b1);
        sbar(1'b0);
        push_frm(ok, ok ? 2'd0 : 2'd3, v, cyc + 7);
        sbar(1'b1);
    endtask

    initial begin
        bif.bar_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_zero = 1'b1;
        @(negedge clock);
        #1;
        chk_zero = 1'b0;
        reset = 1'b0;
        space(5);

        run_frame(16'h4321);
        space(10);

        // Second digit with three wide bars.
        send_start();
        push_dig(0, 4'd1);
        send_digit(4'd1);
        push_frm(1'b0, 2'd1, 16'h0001, -1);
        sbar(1'b1); sbar(1'b1); sbar(1'b1); sbar(1'b0); sbar(1'b0);
        space(10);
        run_frame(16'h5709);
        space(10);

        // Space timeout right after the start pattern.
        sbar(1'b1);
        sbar(1'b1);
        bar_hi(2);
        push_frm(1'b0, 2'd2, 16'h0000, cyc + 32);
        space(40);

        // Saturated bar as the first data bar.
        send_start();
        push_frm(1'b0, 2'd3, 16'h0000, cyc + 301);
        bar_hi(300);
        space(5);

        // Reset in the middle of the second digit.
        send_start();
        push_dig(0, 4'd1);
        send_digit(4'd1);
        sbar(1'b1);
        bar_hi(3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_zero = 1'b1;
        @(negedge clock);
        #1;
        chk_zero = 1'b0;
        reset = 1'b0;
        space(3);
        run_frame(16'h4321);
        space(6);

        run_frame(16'h6321);
        space(6);
        run_frame(16'h5321);
        space(10);

        chk_end = 1'b1;
        @(negedge clock);
        #1;
        chk_end = 1'b0;
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
